// File: rtl/msfsm_transition_scheduler.sv
// Round-robin firing scheduler for Petri-net-derived Mealy FSMs: one fire pulse per 3-cycle slot.
// Optional stall/deadlock detector enabled by defining MSFSM_SCHED_STALL_DET_EN.
module msfsm_transition_scheduler #(
   parameter int unsigned NT        = 8,
   parameter int unsigned STALL_LIM = 255
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [NT-1:0]         i_t_req,
   input  logic [NT-1:0]         i_t_en,
   input  logic                  i_pause,
   output logic [NT-1:0]         o_t_fire,
   output logic                  o_busy,
   output logic [$clog2(NT)-1:0] o_last_grant,
   output logic [15:0]           o_fire_cnt,
   output logic                  o_deadlock
);

   localparam int unsigned IW = $clog2(NT);

   typedef enum logic [1:0] {StIdle, StFire, StSettle} state_t;

   state_t          r_state;
   logic [NT-1:0]   r_fire;
   logic            r_busy;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_gidx;
   logic [IW-1:0]   r_last;
   logic [15:0]     r_cnt;

   logic [NT-1:0]   w_elig;
   logic            w_found;
   logic [IW-1:0]   w_gidx;
   logic [IW:0]     w_pos;
   logic [IW-1:0]   w_ptr_nxt;

   assign w_elig = i_t_req & i_t_en;

   // First eligible index at or above r_ptr, wrapping NT-1 -> 0.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_pos   = '0;
      for (int unsigned k = 0; k < NT; k++) begin
         w_pos = {1'b0, r_ptr} + (IW+1)'(k);
         if (w_pos >= (IW+1)'(NT)) begin
            w_pos = w_pos - (IW+1)'(NT);
         end
         if (!w_found && w_elig[w_pos[IW-1:0]]) begin
            w_found = 1'b1;
            w_gidx  = w_pos[IW-1:0];
         end
      end
   end

   assign w_ptr_nxt = (r_gidx == IW'(NT-1)) ? '0 : r_gidx + IW'(1);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= StIdle;
         r_fire  <= '0;
         r_busy  <= 1'b0;
         r_ptr   <= '0;
         r_gidx  <= '0;
         r_last  <= '0;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_found && !i_pause) begin
                  r_state <= StFire;
                  r_fire  <= NT'(1) << w_gidx;
                  r_gidx  <= w_gidx;
                  r_busy  <= 1'b1;
               end
            end
            StFire: begin
               r_state <= StSettle;
               r_fire  <= '0;
               r_ptr   <= w_ptr_nxt;
               r_last  <= r_gidx;
               r_cnt   <= r_cnt + 16'd1;
            end
            StSettle: begin
               // Gives FSM place outputs a cycle to reflect the firing before t_en is re-sampled.
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= StIdle;
               r_fire  <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_t_fire     = r_fire;
   assign o_busy       = r_busy;
   assign o_last_grant = r_last;
   assign o_fire_cnt   = r_cnt;

`ifdef MSFSM_SCHED_STALL_DET_EN
   localparam logic [15:0] StallLim = 16'(STALL_LIM);

   logic [15:0] r_stall_cnt;
   logic [15:0] w_stall_nxt;
   logic        r_deadlock;

   always_comb begin
      w_stall_nxt = r_stall_cnt;
      if ((w_elig != '0) || (i_t_req == '0)) begin
         w_stall_nxt = '0;
      end else if (!i_pause && (r_state == StIdle) && (r_stall_cnt < StallLim)) begin
         w_stall_nxt = r_stall_cnt + 16'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_stall_cnt <= '0;
         r_deadlock  <= 1'b0;
      end else begin
         r_stall_cnt <= w_stall_nxt;
         r_deadlock  <= (w_stall_nxt == StallLim);
      end
   end

   assign o_deadlock = r_deadlock;
`else
   assign o_deadlock = 1'b0;
`endif

endmodule

// File: doc/msfsm_transition_scheduler.md
# msfsm_transition_scheduler

Central firing scheduler for a set of multi-synchronous Mealy FSMs derived from one Petri net. It collects per-transition firing requests and enables, and grants at most one transition per firing slot using round-robin arbitration. Enables come from the FSMs' place outputs, so conflicting transitions at a choice place are resolved fairly rather than by fixed `if/else if` priority. The scheduler drives the FSMs' `t*_` inputs with a one-cycle fire pulse and waits for the place outputs to settle before arbitrating again.

## Interface
Parameters:
- `NT`, 8: number of transitions scheduled (2..32).
- `STALL_LIM`, 255: IDLE cycles with pending-but-unenabled requests before `deadlock` asserts (1..65535).

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `t_req`, input, NT: bit i = environment requests transition i. Held until `t_fire[i]` is seen.
- `t_en`, input, NT: bit i = transition i enabled, meaning all input places are marked (AND of FSM place outputs). Includes the barrier conditions for shared transitions.
- `pause`, input, 1: high = no new grants. A slot already in progress completes.
- `t_fire`, output, NT: one-hot pulse lasting one cycle. Drives `t*_` and the `*_TB` inputs of every FSM sharing the transition.
- `busy`, output, 1: high in FIRE and SETTLE.
- `last_grant`, output, clog2(NT): index of the most recent fired transition.
- `fire_cnt`, output, 16: total firings, wraps modulo 2^16.
- `deadlock`, output, 1: stall indication (see Configuration).

## Operation
- `elig = t_req & t_en`, computed combinationally each cycle.
- States: IDLE, FIRE, SETTLE. Reset state is IDLE.
- IDLE → FIRE when `elig != 0` and `pause == 0`.
  - Grant the first set bit of `elig` scanning upward from `ptr`, wrapping from NT-1 to 0.
  - Register the grant as a one-hot value.
- FIRE → SETTLE unconditionally.
  - `t_fire` = registered grant.
  - `ptr` ← (grant index + 1) mod NT.
  - `last_grant` ← grant index.
  - `fire_cnt` ← `fire_cnt` + 1.
- SETTLE → IDLE unconditionally. `t_fire` = 0. This cycle lets the FSM state registers and their place outputs reflect the firing before `t_en` is re-sampled.
- Grant is decided from values sampled in IDLE. Changes to `t_req`/`t_en` during FIRE or SETTLE do not alter the pulse in flight.
- A transition whose `t_req` drops before its grant is never fired.
- Simultaneous eligible transitions (choice conflict): exactly one fires per slot. With persistent requests, the round-robin pointer guarantees each of k eligible transitions fires within k slots.
- `pause` rising during FIRE or SETTLE: the current slot completes, and no new grant is made while `pause` stays high.
- Reset value of every output is 0: `t_fire`, `busy`, `last_grant`, `fire_cnt`, `deadlock`. `ptr` also resets to 0.
- Reset asserted mid-slot: the pulse is aborted immediately and asynchronously, and the slot is not counted.

## Timing
- Latency: `elig` nonzero at rising edge k (state IDLE) → `t_fire` high during cycle k+1 → low in cycle k+2. The next grant is possible at edge k+3.
- Peak throughput: one firing per 3 cycles.
- `t_fire`, `busy`, `last_grant`, `fire_cnt` and `deadlock` are all registered, with no combinational path from inputs.
- `t_fire` is high for exactly one cycle per grant.

## Configuration
- `MSFSM_SCHED_STALL_DET_EN` defined:
  - A 16-bit `stall_cnt` increments each IDLE cycle with `t_req != 0`, `elig == 0` and `pause == 0`, saturating at `STALL_LIM`.
  - `stall_cnt` clears on any cycle where `elig != 0` or `t_req == 0`.
  - `deadlock` = (`stall_cnt` == `STALL_LIM`), registered. It remains high until the clear condition occurs.
  - `pause` high holds `stall_cnt` at its current value.
- Macro undefined: no stall counter is built and `deadlock` is tied to 0.

## Test plan
- Single request: `t_req=8'h02`, `t_en=8'h02` in IDLE.
  - Expect `t_fire=8'h02` exactly one cycle later, `busy` high for 2 cycles, `fire_cnt=1`, `last_grant=1`.
- Choice conflict: `t_req=8'h06`, `t_en=8'h06` held, `ptr=0`.
  - Expect fires in order `8'h02`, `8'h04`, `8'h02`, `8'h04`, spaced 3 cycles apart.
- Wrap-around: `ptr=7` after firing index 6; `elig=8'h81`.
  - Expect index 7 fires, then index 0.
- Pause: assert `pause` in the FIRE cycle.
  - Expect the current pulse to complete and no further `t_fire` while `pause=1`.
  - After release, the next grant appears 1 cycle later.
- Stall (macro defined, `STALL_LIM=4`): `t_req=8'h01`, `t_en=0`.
  - Expect `deadlock=1` after 4 IDLE cycles.
  - Raising `t_en[0]` clears `deadlock` and fires index 0.
- Async reset: drive `reset=0` during the FIRE cycle.
  - Expect `t_fire=0` immediately and all outputs 0.
  - After release, a held request fires starting from `ptr=0`.
